// File: rtl/nmr_seq_pkg.sv
// Shared types and widths for the NMR pulse sequence decoder.
package nmr_seq_pkg;

    localparam int CNT_W  = 32;
    localparam int BCNT_W = 16;

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [BCNT_W-1:0] BCNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        A_PULSE,
        AB_GAP,
        B_PULSE,
        BB_GAP,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        BLK_OFF,
        BLK_WAIT,
        BLK_RUN,
        BLK_FIN
    } blank_phase_t;

    // True when two microsecond lengths are more than 1 us apart.
    function automatic logic diff_gt_one(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        if (a > b)
            return (a - b) > CNT_W'(1);
        else
            return (b - a) > CNT_W'(1);
    endfunction

endpackage

// File: rtl/us_tick_counter.sv
// Prescaled microsecond counter with synchronous clear and saturation.
// us_count already includes the tick that the current enabled cycle produces.
module us_tick_counter #(
    parameter int unsigned DIVIDER = 125,
    parameter int          W       = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] us_count
);

    localparam int PW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

    logic [PW-1:0] presc;
    logic [W-1:0]  count;
    logic          wrap;

    assign wrap = en && (presc == PW'(DIVIDER - 1));

    always_comb begin
        us_count = count;
        if (wrap && (count != '1))
            us_count = count + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            count <= '0;
        end else if (clr) begin
            presc <= '0;
            count <= '0;
        end else if (en) begin
            presc <= wrap ? '0 : presc + 1'b1;
            count <= us_count;
        end
    end

endmodule

// File: rtl/nmr_pulse_sequence_decoder.sv
// Passive monitor of the pulse sequencer bus; measures A/B pulse timing and
// the first blanking run in microseconds and strobes the results once per sequence.
module nmr_pulse_sequence_decoder
    import nmr_seq_pkg::*;
#(
    parameter int unsigned US_DIVIDER = 125,
    parameter int unsigned TIMEOUT_US = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enbl,
    input  logic              sync_in,
    input  logic              pulse_in,
    input  logic              blank_in,
    output logic [CNT_W-1:0]  Alen_out,
    output logic [CNT_W-1:0]  Blen_out,
    output logic [CNT_W-1:0]  ABdly_out,
    output logic [CNT_W-1:0]  BBdly_out,
    output logic [BCNT_W-1:0] BBcnt_out,
    output logic [CNT_W-1:0]  BlankLen_out,
    output logic              valid_out,
    output logic              err_out,
    output logic              abort_out,
    output logic              busy_out
);

    logic sync_q, sync_d, pulse_q, pulse_d, blank_q, blank_d;
    logic sync_rise, pulse_rise, pulse_fall;

    state_t       state, next_state;
    blank_phase_t blank_phase;

    logic [CNT_W-1:0]  seg_us, blank_us;
    logic              seg_en, seg_clr, blank_en, timeout;
    logic              arm, abort;

    logic [CNT_W-1:0]  alen_w, blen_w, abdly_w, bbdly_w;
    logic [CNT_W-1:0]  alen_n, blen_n, abdly_n, bbdly_n;
    logic [BCNT_W-1:0] bbcnt_w, bbcnt_n;
    logic              err_w, err_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 1'b0;
            sync_d  <= 1'b0;
            pulse_q <= 1'b0;
            pulse_d <= 1'b0;
            blank_q <= 1'b0;
            blank_d <= 1'b0;
        end else begin
            sync_q  <= sync_in;
            sync_d  <= sync_q;
            pulse_q <= pulse_in;
            pulse_d <= pulse_q;
            blank_q <= blank_in;
            blank_d <= blank_q;
        end
    end

    assign sync_rise  = sync_q & ~sync_d;
    assign pulse_rise = pulse_q & ~pulse_d;
    assign pulse_fall = ~pulse_q & pulse_d;

    assign seg_en  = (state != IDLE) && (state != DONE);
    assign seg_clr = (next_state != state) || arm;
    assign timeout = seg_us >= CNT_W'(TIMEOUT_US);

    us_tick_counter #(.DIVIDER(US_DIVIDER), .W(CNT_W)) u_seg_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (seg_clr),
        .en       (seg_en),
        .us_count (seg_us)
    );

    // Blank path only counts the first high run after the sequence was armed.
    assign blank_en = blank_d && ((blank_phase == BLK_WAIT) || (blank_phase == BLK_RUN));

    us_tick_counter #(.DIVIDER(US_DIVIDER), .W(CNT_W)) u_blank_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (arm),
        .en       (blank_en),
        .us_count (blank_us)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            blank_phase <= BLK_OFF;
        else if (arm)
            blank_phase <= BLK_WAIT;
        else if ((blank_phase == BLK_WAIT) && blank_d)
            blank_phase <= BLK_RUN;
        else if ((blank_phase == BLK_RUN) && !blank_d)
            blank_phase <= BLK_FIN;
    end

    always_comb begin
        next_state = state;
        arm        = 1'b0;
        abort      = 1'b0;
        alen_n     = alen_w;
        blen_n     = blen_w;
        abdly_n    = abdly_w;
        bbdly_n    = bbdly_w;
        bbcnt_n    = bbcnt_w;
        err_n      = err_w;

        if (!enbl) begin
            next_state = IDLE;
        end else if (sync_rise) begin
            arm        = 1'b1;
            abort      = (state != IDLE) && (state != DONE);
            next_state = ARMED;
        end else begin
            unique case (state)
                IDLE: next_state = IDLE;
                ARMED: begin
                    if (pulse_rise) begin
                        next_state = A_PULSE;
                    end else if (timeout) begin
                        err_n      = 1'b1;
                        next_state = DONE;
                    end
                end
                A_PULSE: begin
                    if (pulse_fall) begin
                        alen_n     = seg_us;
                        next_state = AB_GAP;
                    end else if (timeout) begin
                        alen_n     = seg_us;
                        err_n      = 1'b1;
                        next_state = DONE;
                    end
                end
                AB_GAP: begin
                    if (pulse_rise) begin
                        abdly_n    = seg_us;
                        bbcnt_n    = BCNT_W'(1);
                        next_state = B_PULSE;
                    end else if (timeout) begin
                        next_state = DONE;
                    end
                end
                B_PULSE: begin
                    if (pulse_fall) begin
                        if (bbcnt_w == BCNT_W'(1))
                            blen_n = seg_us;
                        else if (diff_gt_one(seg_us, blen_w))
                            err_n = 1'b1;
                        next_state = BB_GAP;
                    end else if (timeout) begin
                        err_n      = 1'b1;
                        next_state = DONE;
                    end
                end
                BB_GAP: begin
                    if (pulse_rise) begin
                        if (bbcnt_w == BCNT_W'(1))
                            bbdly_n = seg_us;
                        if (bbcnt_w != BCNT_MAX)
                            bbcnt_n = bbcnt_w + 1'b1;
                        next_state = B_PULSE;
                    end else if (timeout) begin
                        next_state = DONE;
                    end
                end
                DONE: next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end

        if (arm) begin
            alen_n  = '0;
            blen_n  = '0;
            abdly_n = '0;
            bbdly_n = '0;
            bbcnt_n = '0;
            err_n   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            alen_w  <= '0;
            blen_w  <= '0;
            abdly_w <= '0;
            bbdly_w <= '0;
            bbcnt_w <= '0;
            err_w   <= 1'b0;
        end else begin
            state   <= next_state;
            alen_w  <= alen_n;
            blen_w  <= blen_n;
            abdly_w <= abdly_n;
            bbdly_w <= bbdly_n;
            bbcnt_w <= bbcnt_n;
            err_w   <= err_n;
        end
    end

    // Results are published on entry to DONE so they line up with the valid strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Alen_out     <= '0;
            Blen_out     <= '0;
            ABdly_out    <= '0;
            BBdly_out    <= '0;
            BBcnt_out    <= '0;
            BlankLen_out <= '0;
            err_out      <= 1'b0;
            valid_out    <= 1'b0;
            abort_out    <= 1'b0;
        end else begin
            valid_out <= (next_state == DONE);
            abort_out <= abort;
            if (next_state == DONE) begin
                Alen_out     <= alen_n;
                Blen_out     <= blen_n;
                ABdly_out    <= abdly_n;
                BBdly_out    <= bbdly_n;
                BBcnt_out    <= bbcnt_n;
                BlankLen_out <= blank_us;
                err_out      <= err_n;
            end
        end
    end

    assign busy_out = (state != IDLE);

endmodule

// File: tb/tb_nmr_pulse_sequence_decoder.sv
// Directed bench for the pulse sequence decoder with hand-computed expectations
// (US_DIVIDER=5, TIMEOUT_US=200).
module tb_nmr_pulse_sequence_decoder;

    logic        clk;
    logic        rst;
    logic        enbl;
    logic        sync_in;
    logic        pulse_in;
    logic        blank_in;
    logic [31:0] Alen_out, Blen_out, ABdly_out, BBdly_out, BlankLen_out;
    logic [15:0] BBcnt_out;
    logic        valid_out, err_out, abort_out, busy_out;

    int checks      = 0;
    int errors      = 0;
    int valid_cnt   = 0;
    int abort_cnt   = 0;
    int exp_valid   = 0;

    nmr_pulse_sequence_decoder #(.US_DIVIDER(5), .TIMEOUT_US(200)) dut (
        .clk          (clk),
        .rst          (rst),
        .enbl         (enbl),
        .sync_in      (sync_in),
        .pulse_in     (pulse_in),
        .blank_in     (blank_in),
        .Alen_out     (Alen_out),
        .Blen_out     (Blen_out),
        .ABdly_out    (ABdly_out),
        .BBdly_out    (BBdly_out),
        .BBcnt_out    (BBcnt_out),
        .BlankLen_out (BlankLen_out),
        .valid_out    (valid_out),
        .err_out      (err_out),
        .abort_out    (abort_out),
        .busy_out     (busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid_out) valid_cnt <= valid_cnt + 1;
        if (abort_out) abort_cnt <= abort_cnt + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // One sequence: sync (with optional blank run), A pulse, nb B pulses, then a
    // long low tail so the gap timeout ends it. The last B may differ in length.
    task automatic applyStimulus(input int blank_len, input int a_len, input int ab_gap,
                                 input int b_len, input int b_last_len, input int bb_gap,
                                 input int nb);
        sync_in  = 1'b1;
        blank_in = (blank_len > 0);
        wait_clk(1);
        sync_in = 1'b0;
        if (blank_len > 0) begin
            wait_clk(blank_len - 1);
            blank_in = 1'b0;
        end
        wait_clk(5);
        if (a_len == 0) begin
            wait_clk(1100);
        end else begin
            pulse_in = 1'b1;
            wait_clk(a_len);
            pulse_in = 1'b0;
            if (nb == 0) begin
                wait_clk(1100);
            end else begin
                wait_clk(ab_gap);
                for (int i = 0; i < nb; i++) begin
                    pulse_in = 1'b1;
                    wait_clk((i == nb - 1) ? b_last_len : b_len);
                    pulse_in = 1'b0;
                    wait_clk((i == nb - 1) ? 1100 : bb_gap);
                end
            end
        end
        exp_valid++;
    endtask

    initial begin
        rst      = 1'b1;
        enbl     = 1'b1;
        sync_in  = 1'b0;
        pulse_in = 1'b0;
        blank_in = 1'b0;
        wait_clk(3);
        checkOutput("reset_alen", Alen_out, 0);
        checkOutput("reset_valid", 32'(valid_out), 0);
        checkOutput("reset_busy", 32'(busy_out), 0);
        checkOutput("reset_bbcnt", 32'(BBcnt_out), 0);
        rst = 1'b0;
        wait_clk(3);

        $display("[TB] full sequence with blank");
        applyStimulus(25, 50, 600, 100, 100, 300, 5);
        checkOutput("main_alen", Alen_out, 10);
        checkOutput("main_abdly", ABdly_out, 120);
        checkOutput("main_blen", Blen_out, 20);
        checkOutput("main_bbdly", BBdly_out, 60);
        checkOutput("main_bbcnt", 32'(BBcnt_out), 5);
        checkOutput("main_blank", BlankLen_out, 5);
        checkOutput("main_err", 32'(err_out), 0);
        checkOutput("main_valid_cnt", valid_cnt, exp_valid);
        checkOutput("main_busy_after", 32'(busy_out), 0);

        $display("[TB] A-only sequences, floor boundary");
        applyStimulus(0, 54, 0, 0, 0, 0, 0);
        checkOutput("a54_alen", Alen_out, 10);
        checkOutput("a54_bbcnt", 32'(BBcnt_out), 0);
        checkOutput("a54_blen", Blen_out, 0);
        checkOutput("a54_abdly", ABdly_out, 0);
        checkOutput("a54_err", 32'(err_out), 0);
        checkOutput("a54_blank", BlankLen_out, 0);
        applyStimulus(0, 55, 0, 0, 0, 0, 0);
        checkOutput("a55_alen", Alen_out, 11);

        $display("[TB] no pulse after sync");
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("nopulse_err", 32'(err_out), 1);
        checkOutput("nopulse_alen", Alen_out, 0);
        checkOutput("nopulse_abdly", ABdly_out, 0);
        checkOutput("nopulse_bbcnt", 32'(BBcnt_out), 0);

        $display("[TB] stuck pulse");
        applyStimulus(0, 1100, 0, 0, 0, 0, 0);
        checkOutput("stuck_err", 32'(err_out), 1);

        $display("[TB] B length mismatch and tolerance");
        applyStimulus(0, 50, 100, 50, 60, 100, 2);
        checkOutput("mism_err", 32'(err_out), 1);
        checkOutput("mism_bbcnt", 32'(BBcnt_out), 2);
        checkOutput("mism_blen", Blen_out, 10);
        checkOutput("mism_bbdly", BBdly_out, 20);
        applyStimulus(0, 50, 100, 50, 55, 100, 2);
        checkOutput("tol_err", 32'(err_out), 0);
        checkOutput("tol_blen", Blen_out, 10);
        checkOutput("valid_cnt_pre_abort", valid_cnt, exp_valid);
        checkOutput("abort_cnt_pre", abort_cnt, 0);

        $display("[TB] abort in BB_GAP then full sequence");
        sync_in = 1'b1;
        wait_clk(1);
        sync_in = 1'b0;
        wait_clk(5);
        pulse_in = 1'b1; wait_clk(50);
        pulse_in = 1'b0; wait_clk(100);
        pulse_in = 1'b1; wait_clk(100);
        pulse_in = 1'b0; wait_clk(50);
        applyStimulus(0, 60, 200, 50, 50, 150, 2);
        checkOutput("abort_pulses", abort_cnt, 1);
        checkOutput("abort_valid_cnt", valid_cnt, exp_valid);
        checkOutput("abort_alen", Alen_out, 12);
        checkOutput("abort_abdly", ABdly_out, 40);
        checkOutput("abort_blen", Blen_out, 10);
        checkOutput("abort_bbdly", BBdly_out, 30);
        checkOutput("abort_bbcnt", 32'(BBcnt_out), 2);
        checkOutput("abort_err", 32'(err_out), 0);

        $display("[TB] async reset mid B pulse");
        sync_in = 1'b1;
        wait_clk(1);
        sync_in = 1'b0;
        wait_clk(5);
        pulse_in = 1'b1; wait_clk(50);
        pulse_in = 1'b0; wait_clk(100);
        pulse_in = 1'b1; wait_clk(20);
        rst = 1'b1;
        #2;
        checkOutput("rst_alen", Alen_out, 0);
        checkOutput("rst_bbcnt", 32'(BBcnt_out), 0);
        checkOutput("rst_busy", 32'(busy_out), 0);
        checkOutput("rst_bbdly", BBdly_out, 0);
        pulse_in = 1'b0;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(3);

        $display("[TB] single B, then enable drop mid sequence");
        applyStimulus(0, 50, 100, 50, 50, 0, 1);
        checkOutput("oneb_alen", Alen_out, 10);
        checkOutput("oneb_abdly", ABdly_out, 20);
        checkOutput("oneb_blen", Blen_out, 10);
        checkOutput("oneb_bbdly", BBdly_out, 0);
        checkOutput("oneb_bbcnt", 32'(BBcnt_out), 1);
        sync_in = 1'b1;
        wait_clk(1);
        sync_in = 1'b0;
        wait_clk(5);
        pulse_in = 1'b1;
        wait_clk(20);
        checkOutput("enbl_busy_before", 32'(busy_out), 1);
        enbl = 1'b0;
        wait_clk(2);
        checkOutput("enbl_busy_low", 32'(busy_out), 0);
        checkOutput("enbl_alen_held", Alen_out, 10);
        checkOutput("enbl_bbcnt_held", 32'(BBcnt_out), 1);
        pulse_in = 1'b0;
        wait_clk(5);
        enbl = 1'b1;
        wait_clk(5);
        checkOutput("enbl_valid_cnt", valid_cnt, exp_valid);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nmr_pulse_sequence_decoder.md
Name: nmr_pulse_sequence_decoder

Overview:
Passive decoder for the NMR pulse sequencer output bus: watches sync/pulse/blank and measures the sequence timing back in microseconds.
Per sequence it reports:
- A length, B length, A-to-B delay, B-to-B delay, B count, blank length.
- A one-cycle valid strobe once the sequence has ended.
Sits beside the sequencer in the same clock domain. Used for readback over the register interface and as a self-checking monitor in benches.

Parameters:
US_DIVIDER, 125, clk cycles per microsecond tick; must match the sequencer setting.
TIMEOUT_US, 1000, a gap or pulse of this many us ends (or faults) the sequence.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
enbl  in  1  decoder enable; low forces IDLE, results held
sync_in  in  1  sequencer sync, synchronous to clk
pulse_in  in  1  sequencer RF pulse gate
blank_in  in  1  sequencer receiver blanking
Alen_out  out  32  measured A pulse length, us
Blen_out  out  32  measured first B pulse length, us
ABdly_out  out  32  A falling edge to first B rising edge, us
BBdly_out  out  32  first B falling edge to second B rising edge, us
BBcnt_out  out  16  number of B pulses
BlankLen_out  out  32  first blank high run after sync, us
valid_out  out  1  one-cycle strobe; result outputs updated in the same cycle
err_out  out  1  fault flag, updated with valid_out
abort_out  out  1  one-cycle pulse when a new sync aborts a measurement
busy_out  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0.
- Input registering and edges:
  - sync_in, pulse_in and blank_in are registered once.
  - Edges are detected between the register stage and its delayed copy.
  - Latency: input edge to state change is 2 clk.
- Measurement units:
  - Segment prescaler counts 0..US_DIVIDER-1 and clears on every FSM transition.
  - The segment counter increments when the prescaler wraps.
  - Measured value = floor(cycles in segment / US_DIVIDER).
  - All counters saturate: 32-bit at all ones, BBcnt at 16'hFFFF.
- FSM states: IDLE, ARMED, A_PULSE, AB_GAP, B_PULSE, BB_GAP, DONE.
  - IDLE: sync rise with enbl=1 -> ARMED; working registers cleared.
  - ARMED: pulse rise -> A_PULSE.
  - A_PULSE: counts Alen; pulse fall -> AB_GAP.
  - AB_GAP: counts ABdly; pulse rise -> B_PULSE, BBcnt=1.
  - B_PULSE: counts the current B length; only the first B is latched to Blen. Pulse fall -> BB_GAP.
  - BB_GAP: counts the gap; only the first gap is latched to BBdly. Pulse rise -> B_PULSE with BBcnt+1.
  - DONE: lasts 1 cycle, pulses valid_out, returns to IDLE.
- Sequence end (gap states):
  - When the gap counter reaches TIMEOUT_US in AB_GAP or BB_GAP, go to DONE with err=0.
  - That gap value is not latched: ABdly=0 if no B arrived; BBdly=0 if only one B arrived.
- Faults (err=1):
  - Timeout in ARMED (no pulse); all lengths 0.
  - Timeout in A_PULSE or B_PULSE (pulse stuck high).
  - Any B length differing from the first B length by more than 1 us.
- Blank path:
  - Independent prescaler and counter.
  - Measures the first blank_in high run after sync rise.
  - If blank_in is still high at DONE, reports the count so far.
- Sync rise in any state other than IDLE or DONE:
  - abort_out pulses, no valid, working registers cleared, go to ARMED.
  - A sync rise seen in the DONE cycle -> ARMED directly, with no abort.
- enbl low:
  - Synchronous return to IDLE next cycle, no valid.
  - Outputs keep the last results.
- Outputs hold between valid strobes.

Decomposition:
- Package nmr_seq_pkg holds:
  - FSM state enum.
  - CNT_W=32 and BCNT_W=16.
  - Saturation constants.
- One sub-module, us_tick_counter: prescaler plus saturating us counter with clear and enable. Instantiated twice, once for the pulse segment and once for the blank path.

Test Plan:
- US_DIVIDER=5, TIMEOUT_US=200. Sync, then pulse high 50 clk, low 600, then 5 pulses of 100 clk high separated by 300 clk low. Blank high 25 clk after sync. After a 1000 clk low gap: Alen=10, ABdly=120, Blen=20, BBdly=60, BBcnt=5, BlankLen=5, err=0, exactly one valid.
- A pulse of 54 clk -> Alen=10 (floor); 55 clk -> Alen=11.
- Sync, A pulse only, then 1000+ clk low -> valid with BBcnt=0, Blen=0, ABdly=0, err=0.
- Sync, no pulse for 1000 clk -> valid, err=1, all lengths 0. Pulse held high 1000+ clk -> err=1.
- Second sync rise during BB_GAP -> abort_out 1-cycle pulse, no valid; the next full sequence decodes correctly.
- rst asserted mid-B_PULSE -> outputs 0 immediately and asynchronously. enbl low mid-sequence -> busy_out low, previous results held.
